// File: rtl/write_decoder_pkg.sv
// Shared types for write_decoder: FIFO state encoding, drop counter width and the write-request payload.
package write_decoder_pkg;

    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned REQ_ADDR_W = 5;
    localparam int unsigned REQ_DATA_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/write_decoder_recursive.sv
// Structural one-hot decoder built from not/and gates; the MSB picks a half, recursing down to a 1-to-2 leaf.
// Present only when GATE_DECODER_EN is defined.
`ifdef GATE_DECODER_EN
module decoder_recursive #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DELAY = 50
) (
    input  logic [$clog2(WIDTH)-1:0] sel,
    input  logic                     en,
    output logic [WIDTH-1:0]         out
);

    localparam int unsigned SEL_W = $clog2(WIDTH);

    logic sel_msb_n;

    not #(DELAY) u_not_msb (sel_msb_n, sel[SEL_W-1]);

    if (WIDTH == 2) begin : g_leaf
        and #(DELAY) u_and_lo (out[0], en, sel_msb_n);
        and #(DELAY) u_and_hi (out[1], en, sel[0]);
    end else begin : g_split
        logic en_lo;
        logic en_hi;

        // Each level adds one AND; the inverters of all levels switch in parallel.
        and #(DELAY) u_and_lo (en_lo, en, sel_msb_n);
        and #(DELAY) u_and_hi (en_hi, en, sel[SEL_W-1]);

        decoder_recursive #(.WIDTH(WIDTH / 2), .DELAY(DELAY)) u_lo (
            .sel (sel[SEL_W-2:0]),
            .en  (en_lo),
            .out (out[WIDTH/2-1:0])
        );

        decoder_recursive #(.WIDTH(WIDTH / 2), .DELAY(DELAY)) u_hi (
            .sel (sel[SEL_W-2:0]),
            .en  (en_hi),
            .out (out[WIDTH-1:WIDTH/2])
        );
    end

endmodule
`endif

// File: rtl/write_decoder.sv
// Register write decoder: valid/ready request into a 2-entry skid FIFO, head decoded to a one-hot write enable.
// GATE_DECODER_EN selects the structural gate-level decoder instead of the behavioural shift.
module write_decoder
    import write_decoder_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned DELAY    = 50
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(WIDTH)-1:0] in_addr,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         wr_en,
    output logic [$clog2(WIDTH)-1:0] wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic                     busy
);

    localparam int unsigned ADDR_W = $clog2(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("write_decoder: WIDTH must be a power of two >= 2");
    end
    if (ADDR_W > REQ_ADDR_W || DATA_W > REQ_DATA_W) begin : g_bad_payload
        $error("write_decoder: WIDTH/DATA_W exceed the request payload fields");
    end
    if (DELAY > 100000) begin : g_bad_delay
        $error("write_decoder: DELAY is not a plausible gate delay");
    end

    fifo_state_e             state_q, state_d;
    wr_req_t                 head_q, head_d;
    wr_req_t                 skid_q, skid_d;
    wr_req_t                 req;
    logic                    in_ready_q, in_ready_d;
    logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
    logic                    accept;
    logic                    is_zero;
    logic                    push;
    logic                    pop;

    // State, payload and counter registers; reset discards any held entries at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            head_q       <= '0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Next-state: handshakes, zero-register drop and FIFO movement.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        skid_d       = skid_q;
        drop_count_d = drop_count_q;

        req.addr = REQ_ADDR_W'(in_addr);
        req.data = REQ_DATA_W'(in_data);

        is_zero = (ZERO_REG < WIDTH) && (32'(in_addr) == ZERO_REG);
        accept  = in_valid && in_ready_q;
        push    = accept && !is_zero;
        pop     = (state_q != EMPTY) && out_ready;

        if (accept && is_zero && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_CNT_W'(1);
        end

        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = req;
                    state_d = ONE;
                end
            end
            ONE: begin
                unique case ({push, pop})
                    2'b10: begin
                        skid_d  = req;
                        state_d = FULL;
                    end
                    2'b01:   state_d = EMPTY;
                    2'b11:   head_d  = req;
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        in_ready_d = (state_d != FULL);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign busy       = out_valid;
    assign wr_addr    = head_q.addr[ADDR_W-1:0];
    assign wr_data    = head_q.data[DATA_W-1:0];
    assign drop_count = drop_count_q;

`ifdef GATE_DECODER_EN
    // out_valid doubles as the decoder enable, so wr_en is zero whenever the FIFO is empty.
    decoder_recursive #(.WIDTH(WIDTH), .DELAY(DELAY)) u_decoder (
        .sel (wr_addr),
        .en  (out_valid),
        .out (wr_en)
    );
`else
    assign wr_en = out_valid ? (WIDTH'(1) << wr_addr) : '0;
`endif

endmodule

// File: tb/tb_write_decoder.sv
// Directed and randomised self-checking bench for write_decoder (default parameters).
`timescale 1ns/1ps
module tb_write_decoder;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned AW     = 5;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [AW-1:0]     in_addr   = '0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              in_ready;
    logic              out_valid;
    logic              busy;
    logic [WIDTH-1:0]  wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .drop_count (drop_count),
        .busy       (busy)
    );

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL reset_wr_en got %h exp 0", wr_en); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 64'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count got %h exp 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid  = 1'b1;
        in_addr   = 5'd5;
        in_data   = 64'hDEAD;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (wr_en !== 32'h0000_0020) begin errors++; $display("FAIL single_wr_en got %h exp 00000020", wr_en); end
        checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL single_wr_addr got %0d exp 5", wr_addr); end
        checks++; if (wr_data !== 64'hDEAD) begin errors++; $display("FAIL single_wr_data got %h exp dead", wr_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b exp 0", out_valid); end
        checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL single_drain_wr_en got %h exp 0", wr_en); end
    endtask

    // One write per cycle with out_ready held high.
    task automatic test_back_to_back();
        logic [AW-1:0]    addrs [4];
        logic [WIDTH-1:0] ens   [4];
        addrs = '{5'd0, 5'd1, 5'd2, 5'd30};
        ens   = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h4000_0000};
        out_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                in_valid = 1'b1;
                in_addr  = addrs[k];
                in_data  = 64'h100 + 64'(k);
            end else begin
                in_valid = 1'b0;
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", k, in_ready); end
            if (k > 0) begin
                checks++; if (wr_en !== ens[k-1]) begin errors++; $display("FAIL b2b_wr_en[%0d] got %h exp %h", k, wr_en, ens[k-1]); end
                checks++; if (wr_data !== 64'h100 + 64'(k - 1)) begin errors++; $display("FAIL b2b_wr_data[%0d] got %h exp %h", k, wr_data, 64'h100 + 64'(k - 1)); end
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 5'd3;
        in_data   = 64'h33;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready0 got %b exp 1", in_ready); end
        @(negedge clk);
        in_addr = 5'd7;
        in_data = 64'h77;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1 got %b exp 1", in_ready); end
        checks++; if (wr_en !== 32'h8) begin errors++; $display("FAIL stall_head3 got %h exp 8", wr_en); end
        @(negedge clk);
        in_addr = 5'd9;
        in_data = 64'h99;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %b exp 0", in_ready); end
        checks++; if (wr_en !== 32'h8) begin errors++; $display("FAIL stall_hold_en got %h exp 8", wr_en); end
        @(negedge clk);
        out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_still_full got %b exp 0", in_ready); end
        checks++; if (wr_data !== 64'h33) begin errors++; $display("FAIL stall_hold_data got %h exp 33", wr_data); end
        checks++; if (wr_addr !== 5'd3) begin errors++; $display("FAIL stall_hold_addr got %0d exp 3", wr_addr); end
        @(negedge clk);
        checks++; if (wr_en !== 32'h80) begin errors++; $display("FAIL stall_second_en got %h exp 80", wr_en); end
        checks++; if (wr_data !== 64'h77) begin errors++; $display("FAIL stall_second_data got %h exp 77", wr_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_reopen got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (wr_en !== 32'h200) begin errors++; $display("FAIL stall_third_en got %h exp 200", wr_en); end
        checks++; if (wr_data !== 64'h99) begin errors++; $display("FAIL stall_third_data got %h exp 99", wr_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_drop();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_addr  = 5'd31;
            in_data  = 64'(i);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid[%0d] got %b exp 0", i, out_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy[%0d] got %b exp 0", i, busy); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid_end got %b exp 0", out_valid); end
        checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL drop_count got %0d exp 3", drop_count); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.drop_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.drop_count_q;
        checks++; if (drop_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preset got %h exp fffe", drop_count); end
        in_valid = 1'b1;
        in_addr  = 5'd31;
        @(negedge clk);
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_first got %h exp ffff", drop_count); end
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", drop_count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 5'd1;
        in_data   = 64'hA1;
        @(negedge clk);
        in_addr = 5'd2;
        in_data = 64'hA2;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got %b exp 0", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
        checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL rmid_wr_en got %h exp 0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL rmid_drop_count got %h exp 0", drop_count); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Random traffic against a queue model of the 2-entry FIFO.
    task automatic test_random();
        logic [AW-1:0]     q_addr [$];
        logic [DATA_W-1:0] q_data [$];
        logic [15:0]       exp_drops;
        logic              exp_ready;
        logic              exp_valid;
        logic [WIDTH-1:0]  exp_en;
        exp_drops = '0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_addr   = AW'($urandom_range(0, 31));
            in_data   = {$urandom, $urandom};
            exp_ready = (q_addr.size() < 2);
            exp_valid = (q_addr.size() > 0);
            exp_en    = exp_valid ? (32'h1 << q_addr[0]) : 32'h0;
            checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", cyc, in_ready, exp_ready); end
            checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b exp %b", cyc, out_valid, exp_valid); end
            checks++; if (wr_en !== exp_en) begin errors++; $display("FAIL rnd_wr_en cyc %0d got %h exp %h", cyc, wr_en, exp_en); end
            checks++; if (drop_count !== exp_drops) begin errors++; $display("FAIL rnd_drop_count cyc %0d got %h exp %h", cyc, drop_count, exp_drops); end
            if (exp_valid) begin
                checks++; if ($countones(wr_en) != 1) begin errors++; $display("FAIL rnd_onehot cyc %0d got %h exp one bit", cyc, wr_en); end
                checks++; if (wr_data !== q_data[0]) begin errors++; $display("FAIL rnd_wr_data cyc %0d got %h exp %h", cyc, wr_data, q_data[0]); end
                if (out_ready) begin
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
            end
            if (in_valid && exp_ready) begin
                if (in_addr == 5'd31) begin
                    if (exp_drops != 16'hFFFF) exp_drops = exp_drops + 16'd1;
                end else begin
                    q_addr.push_back(in_addr);
                    q_data.push_back(in_data);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_drop();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_decoder.md
# write_decoder

Write-side counterpart of the recursive read mux: accepts a register write (index + data) through a valid/ready handshake and decodes the index into a one-hot write-enable vector. The vector drives a WIDTH-entry register file or any multi-destination storage. It sits between the write-back stage and the register file. A 2-entry skid buffer absorbs register-file stalls, and writes to the hard-wired zero register are dropped and counted.

## Interface
- WIDTH, 32, number of destinations; power of two ≥ 2, checked by an initial assertion
- DATA_W, 64, write data width
- ZERO_REG, 31, index whose writes are discarded; set ≥ WIDTH to disable dropping
- DELAY, 50, gate delay in ps, used only by the gate-level decoder build
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  write request present
- in_ready  output  1  block can accept a request this cycle
- in_addr  input  $clog2(WIDTH)  destination index
- in_data  input  DATA_W  write data
- out_valid  output  1  wr_en/wr_data hold a write
- out_ready  input  1  register file consumes the write this cycle
- wr_en  output  WIDTH  one-hot enable; all zero when out_valid=0
- wr_addr  output  $clog2(WIDTH)  index of the presented write
- wr_data  output  DATA_W  data of the presented write
- drop_count  output  16  saturating count of dropped ZERO_REG writes
- busy  output  1  at least one entry held

## Operation
- Request accepted when in_valid && in_ready.
- Output write consumed when out_valid && out_ready.
- Accepted request with in_addr == ZERO_REG: not enqueued; drop_count += 1, saturating at 16'hFFFF.
- Other accepted requests enter a 2-entry FIFO (head and skid slot). State machine states:
  - EMPTY: push → ONE.
  - ONE: push without pop → FULL; pop without push → EMPTY; push with pop → ONE, new entry becomes head.
  - FULL: pop → ONE, skid entry moves to head; no push possible.
- in_ready = (state != FULL), driven from a register and independent of in_valid/out_ready in the same cycle.
- out_valid = (state != EMPTY). busy = out_valid.
- wr_en = decode(head addr) & {WIDTH{out_valid}}; exactly one bit set when valid.
- While out_valid && !out_ready: wr_addr, wr_data and wr_en stay stable.
- FIFO order preserved; no request lost or duplicated.

## Timing
- Latency: request accepted at edge N is presented at edge N, i.e. out_valid is high the cycle after acceptance (1 cycle), assuming FIFO was EMPTY or head popped at N.
- Throughput: one write per cycle with out_ready held high.
- Reset (asynchronous assert, synchronous release by the clock domain):
  - State → EMPTY.
  - in_ready=1, out_valid=0, wr_en=0, wr_addr=0, wr_data=0, drop_count=0, busy=0.
- Reset mid-operation discards all held entries immediately.
- Dropped write with FIFO FULL: in_ready is low, so nothing is accepted and nothing is counted.
- drop_count updates at the accepting edge.

## Configuration
- GATE_DECODER_EN defined: the one-hot decoder is built structurally from not/and primitives with #DELAY per gate. It uses a recursive 1-to-2 split (MSB selects half). Output settles DELAY·(log2 WIDTH + 1) ps after head change.
- GATE_DECODER_EN undefined: behavioural decoder (1 << addr), zero delay.
- Registered behaviour is identical in both builds.

## Structure
- Shared package: FIFO state enum (EMPTY, ONE, FULL), DROP_CNT_W = 16 constant, and the write-request struct {addr, data}.
- One sub-module: decoder_recursive #(WIDTH, DELAY) (sel, en, out[WIDTH-1:0]). It implements the structural decoder and is used only under GATE_DECODER_EN.
- FIFO, state machine and counter live in write_decoder.

## Test plan
- Reset, then send addr=5, data=0xDEAD with out_ready=1 → next cycle out_valid=1, wr_en=32'h0000_0020, wr_data=0xDEAD; following cycle out_valid=0.
- Hold out_ready=0 and send addr 3, 7, 9 back-to-back → 3 and 7 accepted, in_ready=0 on the third. Release out_ready → writes appear in order 3, 7, then 9; wr_en=0x8, 0x80, 0x200.
- Send addr=31 three times → no out_valid pulse, drop_count=3, busy stays 0.
- Preset drop_count near saturation (force 16'hFFFE), then 3 drops → drop_count=16'hFFFF.
- Assert reset_n=0 mid-cycle with FIFO FULL → out_valid, wr_en, busy go 0 immediately and in_ready=1 without a clock edge.
- Random valid/out_ready for 10,000 cycles against a scoreboard queue → order and data match, wr_en is one-hot whenever out_valid=1.
